// File: rtl/instr_stream_encoder_pkg.sv
// Shared encoding constants, encoder op enum and FSM state type for the
// instruction stream encoder and its word packer.
package instr_stream_encoder_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam int ENC_OP_NUM = 19;

    typedef enum logic [4:0] {
        ENC_ADD  = 5'd0,  ENC_SUB  = 5'd1,  ENC_ADDU = 5'd2,  ENC_SUBU = 5'd3,
        ENC_SLT  = 5'd4,  ENC_SLL  = 5'd5,  ENC_SRL  = 5'd6,  ENC_SRA  = 5'd7,
        ENC_AND  = 5'd8,  ENC_OR   = 5'd9,  ENC_ORI  = 5'd10, ENC_ANDI = 5'd11,
        ENC_SLTI = 5'd12, ENC_LUI  = 5'd13, ENC_LW   = 5'd14, ENC_SW   = 5'd15,
        ENC_BEQ  = 5'd16, ENC_BNE  = 5'd17, ENC_J    = 5'd18
    } enc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request bus (valid/ready) plus instruction-memory write port of the encoder.
// A request transfers on a rising edge where in_valid and in_ready are both high.
interface instr_stream_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_word_pack.sv
// Combinational packer: encoder op plus fields to one 32-bit MIPS word.
// Fields that the chosen format does not use are forced to zero.
module instr_word_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = (32'(op) >= ENC_OP_NUM);
        case (op)
            ENC_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
            ENC_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
            ENC_ADDU: word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
            ENC_SUBU: word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
            ENC_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
            ENC_AND:  word = r_word(rs, rt, rd, 5'd0, FN_AND);
            ENC_OR:   word = r_word(rs, rt, rd, 5'd0, FN_OR);
            // shifts take their operand from rt, so rs is meaningless
            ENC_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            ENC_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
            ENC_SRA:  word = r_word(5'd0, rt, rd, shamt, FN_SRA);
            ENC_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            ENC_ANDI: word = i_word(OPC_ANDI, rs, rt, imm);
            ENC_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
            ENC_LUI:  word = i_word(OPC_LUI, 5'd0, rt, imm);
            ENC_LW:   word = i_word(OPC_LW, rs, rt, imm);
            ENC_SW:   word = i_word(OPC_SW, rs, rt, imm);
            ENC_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
            ENC_BNE:  word = i_word(OPC_BNE, rs, rt, imm);
            ENC_J:    word = {OPC_J, target};
            default:  word = '0;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes field-level requests, buffers them in a small FIFO and writes them
// to consecutive instruction-memory words starting at a latched base address.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  finish,
    instr_stream_encoder_if.slave bus,
    output logic [ADDR_W:0]       word_cnt,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_wrap,
    output state_t                state
);

    localparam int PTR_W = $clog2(DEPTH);

    state_t            next_state;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              ready;
    logic              hs;
    logic              push;
    logic              pop;
    logic              restart;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    instr_word_pack u_pack (
        .op      (bus.in_op),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .shamt   (bus.in_shamt),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign fifo_full    = (count == (PTR_W + 1)'(DEPTH));
    assign fifo_empty   = (count == '0);
    assign bus.in_ready = ready;
    assign hs           = bus.in_valid && ready;
    // illegal requests complete the handshake but never enter the FIFO
    assign push         = hs && !enc_illegal;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        restart    = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    restart    = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready = !fifo_full;
                pop   = !fifo_empty;
                if (finish) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                pop = !fifo_empty;
                if (fifo_empty) next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    restart    = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
        end else begin
            bus.im_we <= pop;
            if (pop) begin
                bus.im_addr  <= addr_q;
                bus.im_wdata <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= '0;
            word_cnt    <= '0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
        end else if (restart) begin
            addr_q      <= base_addr;
            word_cnt    <= '0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
        end else begin
            if (pop) begin
                addr_q <= addr_q + 1'b1;
                if (addr_q == '1)   err_wrap <= 1'b1;
                if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            end
            if (hs && enc_illegal) err_illegal <= 1'b1;
        end
    end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Encoder/loader that produces the machine words the single-cycle control decoder consumes.
- Accepts field-level instruction requests: op select plus rs/rt/rd/shamt/imm/target.
- Packs each request into a 32-bit MIPS word, buffers it in a small FIFO, and writes it sequentially into instruction memory through a write port.
- Sits between the testbench or boot path and the instruction memory; it is the write-side counterpart of the instruction decode path.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2)
- ADDR_W, 8, word-address width of the instruction-memory write port

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches base_addr and enters LOAD
- base_addr  in  ADDR_W  first word address for the stream
- finish  in  1  pulse; stop accepting, drain FIFO, go to DONE
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_op  in  5  encoder op select (package enum)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shamt fields
- in_imm  in  16  immediate/offset
- in_target  in  26  jump target field
- im_we  out  1  instruction-memory write strobe
- im_addr  out  ADDR_W  word address
- im_wdata  out  32  encoded instruction
- word_cnt  out  ADDR_W+1  words written since start
- done  out  1  high in DONE
- err_illegal  out  1  sticky; an unsupported in_op was consumed
- err_wrap  out  1  sticky; address counter wrapped

Behaviour:
- Reset values, all outputs and state: state=IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, word_cnt=0, done=0, err_illegal=0, err_wrap=0, FIFO empty. Reset mid-operation discards all FIFO contents; no write follows.
- Encoding (combinational, sub-module):
  - R-type: {6'h00, rs, rt, rd, shamt, funct}. ADD=20, ADDU=21, SUB=22, SUBU=23, AND=24, OR=25, SLT=2A (hex).
  - For every non-shift R-type, shamt is forced to 0.
  - SLL=00, SRL=02, SRA=03: rs forced to 0; shamt taken from in_shamt.
  - I-type: {op, rs, rt, imm}. ORI=0D, ANDI=0C, SLTI=0A, LW=23, SW=2B, BEQ=04, BNE=05 (hex).
  - LUI=0F: rs forced to 0.
  - J=02: {op, target}.
- States:
  - IDLE: in_ready=0. On start: address counter ← base_addr, word_cnt ← 0, errors cleared, go to LOAD.
  - LOAD: in_ready = !fifo_full. On finish: go to DRAIN; a handshake in the same cycle is still accepted.
  - DRAIN: in_ready=0; the FIFO keeps emptying. When the FIFO is empty go to DONE.
  - DONE: done=1, in_ready=0. On start: re-enter LOAD with the new base address, clearing counters and errors.
  - start in LOAD or DRAIN is ignored.
- Latency:
  - An accepted request is pushed on the same edge.
  - The earliest im_we for it is the following cycle; there is no bypass.
  - Pop/write rate is 1 word per cycle while the FIFO is non-empty in LOAD or DRAIN.
  - im_we, im_addr and im_wdata are registered together.
- Push and pop in the same cycle are allowed. Full with no pop deasserts in_ready. Empty produces no write.
- Illegal in_op (outside the enum):
  - The request is consumed (handshake completes) but not pushed.
  - err_illegal sets and stays set until the next start.
- Address:
  - The counter increments after each write.
  - At 2^ADDR_W-1 it wraps to 0 and sets err_wrap (sticky); the write itself still occurs.
  - word_cnt increments per write and saturates at its maximum.

Decomposition:
- Shared package/header (extend the instruction definition header):
  - opcode and funct constants
  - 5-bit encoder op enum: ADD, SUB, ADDU, SUBU, SLT, SLL, SRL, SRA, AND, OR, ORI, ANDI, SLTI, LUI, LW, SW, BEQ, BNE, J (values 0..18)
  - ENC_OP_NUM = 19
- One sub-module, instr_word_pack: purely combinational; in_op and fields in, {word, illegal} out.
- The FIFO stays inline.

Test Plan:
- Reset, start with base_addr=8'h10, push ADD rs=1 rt=2 rd=3 → next cycle im_we=1, im_addr=10, im_wdata=32'h00221820, word_cnt=1.
- Push ORI rs=0 rt=5 imm=16'h00FF, then LW rs=29 rt=8 imm=16'hFFFC, then J target=26'h0000040 → im_wdata=3405_00FF, 8FA8_FFFC, 0800_0040 at consecutive addresses.
- Push SLL rs=7 rt=4 rd=2 shamt=3 (rs must be ignored) → 32'h000410C0. Push LUI rs=9 rt=1 imm=16'h1234 → 32'h3C01_1234.
- Hold the im path full-rate and push 6 back-to-back requests with DEPTH=4 → in_ready never drops (push/pop balance). Pulse finish on the last push → DRAIN, then DONE after the final write, with done=1.
- in_op=5'd25 mid-stream → handshake completes, no write, err_illegal=1. A following valid op is written at the next address with no gap in addresses.
- base_addr=8'hFE, push 3 words → addresses FE, FF, 00 and err_wrap=1. Assert rstn=0 while 2 words are still buffered → no further im_we, all outputs return to their reset values.
